// File: rtl/ddr_lane_pause_ctrl_if.sv
// Pause request/response bundle between lane-control logic (master) and
// ddr_lane_pause_ctrl (slave).
interface ddr_lane_pause_ctrl_if #(
  parameter int NUM_LANES = 4
);
  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE;
  logic [NUM_LANES-1:0] LANE_EN;
  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC;
  logic [NUM_LANES-1:0] PAUSE_DONE;
  logic                 PAUSE_BUSY;

  modport master (
    output HS_IO_CLK_PAUSE,
    output LANE_EN,
    input  HS_IO_CLK_PAUSE_SYNC,
    input  PAUSE_DONE,
    input  PAUSE_BUSY
  );

  modport slave (
    input  HS_IO_CLK_PAUSE,
    input  LANE_EN,
    output HS_IO_CLK_PAUSE_SYNC,
    output PAUSE_DONE,
    output PAUSE_BUSY
  );
endinterface

// File: rtl/ddr_lane_pause_ctrl.sv
// Multi-lane HS IO clock-pause synchroniser with per-lane minimum pulse width and gap.
// Define PAUSE_SYNC_GANG_EN to drive all lanes from one shared FSM (lane-aligned pauses).
module ddr_lane_pause_ctrl #(
  parameter int NUM_LANES   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 4,
  parameter int MIN_GAP     = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ddr_lane_pause_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_FOLLOW,
    ST_GAP
  } state_t;

  localparam int MAX_CNT = (MIN_PULSE > MIN_GAP) ? MIN_PULSE : MIN_GAP;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

`ifdef PAUSE_SYNC_GANG_EN
  localparam int NUM_FSM = 1;
`else
  localparam int NUM_FSM = NUM_LANES;
`endif

  logic [NUM_LANES-1:0] s;

  // Request synchroniser; depth 0 feeds the raw request straight to the FSMs.
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s = bus.HS_IO_CLK_PAUSE;
    end else begin : g_sync
      logic [NUM_LANES-1:0] sync_q [SYNC_STAGES];

      // NOTE: every flop here is cleared by the synchronous RESET, so no stale
      // request can leak out of the chain after reset.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
        end else begin
          // NOTE: non-blocking assignments keep the shift order-independent.
          sync_q[0] <= bus.HS_IO_CLK_PAUSE;
          for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [NUM_FSM-1:0]   fsm_req;
  logic [NUM_FSM-1:0]   fsm_en;
  logic [NUM_FSM-1:0]   fsm_act;
  logic [NUM_FSM-1:0]   fsm_busy;
  logic [NUM_LANES-1:0] lane_act;
  logic [NUM_LANES-1:0] done_mask;

`ifdef PAUSE_SYNC_GANG_EN
  assign fsm_req   = |(s & bus.LANE_EN);
  assign fsm_en    = 1'b1;
  assign lane_act  = {NUM_LANES{fsm_act[0]}} & bus.LANE_EN;
  assign done_mask = bus.LANE_EN;
`else
  assign fsm_req   = s;
  assign fsm_en    = bus.LANE_EN;
  assign lane_act  = fsm_act;
  assign done_mask = '1;
`endif

  state_t             state_q [NUM_FSM];
  state_t             state_d [NUM_FSM];
  logic [CNT_W-1:0]   cnt_q   [NUM_FSM];
  logic [CNT_W-1:0]   cnt_d   [NUM_FSM];
  logic [NUM_FSM-1:0] pend_q;
  logic [NUM_FSM-1:0] pend_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NUM_FSM; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int k = 0; k < NUM_FSM; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      pend_q <= pend_d;
    end
  end

  always_comb begin
    // NOTE: hold-current defaults first so no path through the case infers a latch.
    pend_d = pend_q;
    for (int k = 0; k < NUM_FSM; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        ST_IDLE: begin
          if (fsm_req[k] && fsm_en[k]) begin
            state_d[k] = ST_HOLD;
            cnt_d[k]   = PULSE_LOAD;
          end
        end
        ST_HOLD: begin
          if (cnt_q[k] != '0) begin
            cnt_d[k] = cnt_q[k] - CNT_W'(1);
          end else if (fsm_req[k]) begin
            state_d[k] = ST_FOLLOW;
          end else if (MIN_GAP > 0) begin
            state_d[k] = ST_GAP;
            cnt_d[k]   = GAP_LOAD;
          end else begin
            state_d[k] = ST_IDLE;
          end
        end
        ST_FOLLOW: begin
          if (!fsm_req[k]) begin
            if (MIN_GAP > 0) begin
              state_d[k] = ST_GAP;
              cnt_d[k]   = GAP_LOAD;
            end else begin
              state_d[k] = ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          // A request arriving inside the gap is remembered and replayed at its end.
          if (cnt_q[k] != '0) begin
            cnt_d[k] = cnt_q[k] - CNT_W'(1);
            if (fsm_req[k]) pend_d[k] = 1'b1;
          end else begin
            pend_d[k] = 1'b0;
            if ((pend_q[k] || fsm_req[k]) && fsm_en[k]) begin
              state_d[k] = ST_HOLD;
              cnt_d[k]   = PULSE_LOAD;
            end else begin
              state_d[k] = ST_IDLE;
            end
          end
        end
        default: state_d[k] = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    fsm_act  = '0;
    fsm_busy = '0;
    for (int k = 0; k < NUM_FSM; k++) begin
      fsm_act[k]  = (state_q[k] == ST_HOLD) || (state_q[k] == ST_FOLLOW);
      fsm_busy[k] = (state_q[k] != ST_IDLE);
    end
  end

  logic [NUM_LANES-1:0] sync_out_q;
  logic [NUM_LANES-1:0] done_q;
  logic                 busy_q;

  // Outputs trail the FSM state by one edge; DONE marks the cycle the output falls.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_out_q <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      sync_out_q <= lane_act;
      done_q     <= sync_out_q & ~lane_act & done_mask;
      busy_q     <= |fsm_busy;
    end
  end

  assign bus.HS_IO_CLK_PAUSE_SYNC = sync_out_q;
  assign bus.PAUSE_DONE           = done_q;
  assign bus.PAUSE_BUSY           = busy_q;

endmodule

// File: tb/tb_ddr_lane_pause_ctrl.sv
// Randomised self-checking bench for ddr_lane_pause_ctrl against a timestamp-based
// reference model, plus directed lane scenarios.
module tb_ddr_lane_pause_ctrl;
  localparam int NL   = 4;
  localparam int SS   = 2;
  localparam int MP   = 4;
  localparam int MG   = 2;
  localparam int MAXT = 4000;
`ifdef PAUSE_SYNC_GANG_EN
  localparam int NM = 1;
`else
  localparam int NM = NL;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr_lane_pause_ctrl_if #(.NUM_LANES(NL)) bus ();

  ddr_lane_pause_ctrl #(
    .NUM_LANES  (NL),
    .SYNC_STAGES(SS),
    .MIN_PULSE  (MP),
    .MIN_GAP    (MG)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_err  = 0;
  int edge_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d got=0x%0h expected=0x%0h", tag, edge_n, got, exp);
    end
  endtask

  // Reference model: each pause/gap is tracked by the edge at which it began.
  int            p_start  [NM];
  int            gap_from [NM];
  bit            want     [NM];
  logic [NM-1:0] act_d1, act_d2;
  logic          busy_d1, rst_d1;
  logic [NL-1:0] en_d1;
  int            last_rst;
  logic [NL-1:0] req_log  [MAXT+1];
  logic [NL-1:0] obs_sync [MAXT+1];
  logic [NL-1:0] obs_done [MAXT+1];
  logic          obs_busy [MAXT+1];

  task automatic model_edge(input int t, input logic [NL-1:0] req, input logic [NL-1:0] en,
                            input logic r, output logic [NL-1:0] e_sync,
                            output logic [NL-1:0] e_done, output logic e_busy);
    logic [NL-1:0] sv;
    logic [NM-1:0] act_now;
    logic          busy_now;
    logic          rk, ek;
`ifdef PAUSE_SYNC_GANG_EN
    e_sync = r ? '0 : ({NL{act_d1[0]}} & en);
    e_done = (r || rst_d1) ? '0 : ({NL{act_d2[0] & ~act_d1[0]}} & en & en_d1);
`else
    e_sync = r ? '0 : act_d1;
    e_done = (r || rst_d1) ? '0 : (act_d2 & ~act_d1);
`endif
    e_busy = !r && busy_d1;

    req_log[t] = req;
    sv = (t > SS && last_rst < t - SS) ? req_log[t-SS] : '0;
    act_now  = '0;
    busy_now = 1'b0;
    for (int k = 0; k < NM; k++) begin
`ifdef PAUSE_SYNC_GANG_EN
      rk = |(sv & en);
      ek = 1'b1;
`else
      rk = sv[k];
      ek = en[k];
`endif
      if (r) begin
        p_start[k] = -1; gap_from[k] = -1; want[k] = 0;
      end else if (p_start[k] >= 0) begin
        if (t - p_start[k] >= MP && !rk) begin
          p_start[k] = -1;
          if (MG > 0) begin gap_from[k] = t; want[k] = 0; end
        end
      end else if (gap_from[k] >= 0) begin
        if (t - gap_from[k] >= MG) begin
          if ((want[k] || rk) && ek) p_start[k] = t;
          gap_from[k] = -1;
          want[k]     = 0;
        end else if (rk) begin
          want[k] = 1;
        end
      end else if (rk && ek) begin
        p_start[k] = t;
      end
      act_now[k] = (p_start[k] >= 0);
      busy_now   = busy_now | (p_start[k] >= 0) | (gap_from[k] >= 0);
    end
    act_d2  = act_d1;
    act_d1  = act_now;
    busy_d1 = busy_now;
    rst_d1  = r;
    en_d1   = en;
    if (r) last_rst = t;
  endtask

  task automatic step(input logic [NL-1:0] req, input logic [NL-1:0] en, input logic r);
    logic [NL-1:0] e_sync, e_done;
    logic          e_busy;
    @(negedge clk);
    bus.HS_IO_CLK_PAUSE = req;
    bus.LANE_EN         = en;
    rst                 = r;
    @(posedge clk);
    edge_n++;
    model_edge(edge_n, req, en, r, e_sync, e_done, e_busy);
    #1;
    obs_sync[edge_n] = bus.HS_IO_CLK_PAUSE_SYNC;
    obs_done[edge_n] = bus.PAUSE_DONE;
    obs_busy[edge_n] = bus.PAUSE_BUSY;
    check("sync", 32'(bus.HS_IO_CLK_PAUSE_SYNC), 32'(e_sync));
    check("done", 32'(bus.PAUSE_DONE), 32'(e_done));
    check("busy", 32'(bus.PAUSE_BUSY), 32'(e_busy));
  endtask

  task automatic idle(input int n, input logic [NL-1:0] en);
    for (int i = 0; i < n; i++) step('0, en, 1'b0);
  endtask

  // sel: 0 = SYNC, 1 = DONE, 2 = BUSY
  function automatic bit obs_bit(input int sel, input int lane, input int t);
    if (sel == 0) return obs_sync[t][lane];
    if (sel == 1) return obs_done[t][lane];
    return obs_busy[t];
  endfunction

  function automatic int cnt_hi(input int sel, input int lane, input int from, input int to);
    int n = 0;
    for (int t = from; t <= to; t++) n += int'(obs_bit(sel, lane, t));
    return n;
  endfunction

  function automatic int first_hi(input int sel, input int lane, input int from, input int to);
    for (int t = from; t <= to; t++) if (obs_bit(sel, lane, t)) return t;
    return -1;
  endfunction

  int            e0;
  int            hold_len [NL];
  logic [NL-1:0] rq, ee;

  initial begin
    for (int k = 0; k < NM; k++) begin
      p_start[k] = -1; gap_from[k] = -1; want[k] = 0;
    end
    act_d1 = '0; act_d2 = '0; busy_d1 = 1'b0; rst_d1 = 1'b1; en_d1 = '0; last_rst = 0;
    bus.HS_IO_CLK_PAUSE = '0;
    bus.LANE_EN         = '0;

    repeat (3) step('0, '1, 1'b1);
    idle(4, '1);

`ifndef PAUSE_SYNC_GANG_EN
    // Single one-cycle request on lane 0.
    e0 = edge_n + 1;
    step(4'b0001, '1, 1'b0);
    idle(11, '1);
    check("s1_rise",  32'(first_hi(0, 0, e0, e0 + 11)), 32'(e0 + 3));
    check("s1_width", 32'(cnt_hi(0, 0, e0, e0 + 11)), 32'd4);
    check("s1_done",  32'(first_hi(1, 0, e0, e0 + 11)), 32'(e0 + 7));
    check("s1_other", 32'(cnt_hi(0, 1, e0, e0 + 11) + cnt_hi(0, 2, e0, e0 + 11)
                          + cnt_hi(0, 3, e0, e0 + 11)), 32'd0);

    // Ten-cycle request on lane 1 stretches the pause to ten cycles.
    e0 = edge_n + 1;
    repeat (10) step(4'b0010, '1, 1'b0);
    idle(8, '1);
    check("s2_width", 32'(cnt_hi(0, 1, e0, e0 + 17)), 32'd10);
    check("s2_done",  32'(first_hi(1, 1, e0, e0 + 17)), 32'(e0 + 13));

    // Second lane-2 request lands in the gap and is deferred.
    e0 = edge_n + 1;
    step(4'b0100, '1, 1'b0);
    idle(4, '1);
    step(4'b0100, '1, 1'b0);
    idle(12, '1);
    check("s3_width",  32'(cnt_hi(0, 2, e0, e0 + 17)), 32'd8);
    check("s3_gap",    32'(cnt_hi(0, 2, e0 + 7, e0 + 8)), 32'd0);
    check("s3_rise2",  32'(first_hi(0, 2, e0 + 7, e0 + 17)), 32'(e0 + 9));
    check("s3_ndone",  32'(cnt_hi(1, 2, e0, e0 + 17)), 32'd2);

    // Disabled lane 3 never pauses and never raises BUSY.
    e0 = edge_n + 1;
    repeat (5) step(4'b1000, 4'b0111, 1'b0);
    idle(6, 4'b0111);
    check("s4_lane3", 32'(cnt_hi(0, 3, e0, e0 + 10)), 32'd0);
    check("s4_busy",  32'(cnt_hi(2, 0, e0, e0 + 10)), 32'd0);

    // Dropping lane 0's enable mid-pause keeps the full width.
    e0 = edge_n + 1;
    step(4'b0001, '1, 1'b0);
    idle(3, '1);
    idle(9, 4'b1110);
    check("s4_drop", 32'(cnt_hi(0, 0, e0, e0 + 12)), 32'd4);
    idle(3, '1);

    // Reset on the second pause edge truncates without DONE.
    e0 = edge_n + 1;
    step(4'b0001, '1, 1'b0);
    idle(3, '1);
    step('0, '1, 1'b1);
    idle(8, '1);
    check("s5_width", 32'(cnt_hi(0, 0, e0, e0 + 12)), 32'd1);
    check("s5_ndone", 32'(cnt_hi(1, 0, e0, e0 + 12)), 32'd0);
    e0 = edge_n + 1;
    step(4'b0001, '1, 1'b0);
    idle(11, '1);
    check("s5_rise", 32'(first_hi(0, 0, e0, e0 + 11)), 32'(e0 + 3));
    check("s5_done", 32'(first_hi(1, 0, e0, e0 + 11)), 32'(e0 + 7));
`else
    // Lanes 0 and 2 requested on different cycles share one waveform.
    e0 = edge_n + 1;
    step(4'b0001, 4'b0111, 1'b0);
    idle(2, 4'b0111);
    step(4'b0100, 4'b0111, 1'b0);
    idle(12, 4'b0111);
    for (int t = e0; t <= edge_n; t++) begin
      check("g_b1", 32'(obs_sync[t][1]), 32'(obs_sync[t][0]));
      check("g_b2", 32'(obs_sync[t][2]), 32'(obs_sync[t][0]));
      check("g_b3", 32'(obs_sync[t][3]), 32'd0);
    end
`endif

    // Bursty random traffic with occasional enable flips and resets.
    ee = '1;
    for (int i = 0; i < NL; i++) hold_len[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NL; i++) begin
        if (hold_len[i] == 0) begin
          rq[i]       = ($urandom_range(0, 2) == 0);
          hold_len[i] = $urandom_range(1, 9);
        end
        hold_len[i]--;
        if ($urandom_range(0, 59) == 0) ee[i] = ~ee[i];
      end
      step(rq, ee, $urandom_range(0, 249) == 0);
    end
    idle(10, '1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
